// File: rtl/audio_envelope_writer_pkg.sv
// Shared types and constants for the audio envelope writer.
package audio_pkg;
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  localparam int SAMPLE_W  = 32;
  localparam int ENV_W_DEF = 8;

  function automatic int env_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int ENV_MAX = env_max(ENV_W_DEF);
endpackage

// File: rtl/audio_envelope_writer_envelope_fsm.sv
// Gated attack/sustain/release envelope with saturating level arithmetic.
module envelope_fsm
  import audio_pkg::*;
#(
  parameter int ENV_W        = ENV_W_DEF,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             gate,
  input  logic             tick,
  output logic [ENV_W-1:0] env_level,
  output logic             active,
  output env_state_t       state
);
  localparam logic [ENV_W:0]   UP_STEP = (ENV_W+1)'(ATTACK_STEP);
  localparam logic [ENV_W:0]   LVL_MAX = (ENV_W+1)'(env_max(ENV_W));
  localparam logic [ENV_W-1:0] DN_STEP = ENV_W'(RELEASE_STEP);

  env_state_t       r_state, w_eff, w_state_nxt;
  logic [ENV_W-1:0] r_level, w_level_nxt;
  logic [ENV_W:0]   w_up;

  assign w_up = {1'b0, r_level} + UP_STEP;

  // Gate changes are resolved first; a coincident tick then steps the level
  // in the state the gate selected.
  always_comb begin
    w_eff       = r_state;
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    case (r_state)
      IDLE:            if (gate)  w_eff = ATTACK;
      ATTACK, SUSTAIN: if (!gate) w_eff = RELEASE;
      RELEASE:         if (gate)  w_eff = ATTACK;
      default:         w_eff = IDLE;
    endcase
    w_state_nxt = w_eff;
    if (tick) begin
      case (w_eff)
        ATTACK:
          if (w_up >= LVL_MAX) begin
            w_level_nxt = LVL_MAX[ENV_W-1:0];
            w_state_nxt = SUSTAIN;
          end else begin
            w_level_nxt = w_up[ENV_W-1:0];
          end
        RELEASE:
          if (r_level <= DN_STEP) begin
            w_level_nxt = '0;
            w_state_nxt = IDLE;
          end else begin
            w_level_nxt = r_level - DN_STEP;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign env_level = r_level;
  assign active    = (r_state != IDLE);
  assign state     = r_state;
endmodule

// File: rtl/audio_envelope_writer.sv
// Scales sine samples by the envelope and feeds the codec write port at a
// fixed three-cycle cadence, one sample in flight at a time.
module audio_envelope_writer
  import audio_pkg::*;
#(
  parameter int ENV_W        = ENV_W_DEF,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 1,
  parameter int TICK_SAMPLES = 48
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                gate,
  input  logic [SAMPLE_W-1:0] wave,
  input  logic                audio_out_allowed,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic                write_audio_out,
  output logic [ENV_W-1:0]    env_level,
  output logic                active
);
  localparam int              CNT_W    = (TICK_SAMPLES > 1) ? $clog2(TICK_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_SAMPLES - 1);
  localparam int              P_W      = SAMPLE_W + ENV_W;

  logic [CNT_W-1:0]    r_tick_cnt;
  logic                r_s0_vld, r_out_vld, r_write;
  logic [SAMPLE_W-1:0] r_s0_wave, r_out_data;
  logic [ENV_W-1:0]    r_s0_lvl, w_level;
  env_state_t          w_state;
  logic                w_issue, w_tick, w_capture;
  logic [P_W-1:0]      w_a, w_b, w_prod;

  envelope_fsm #(
    .ENV_W(ENV_W), .ATTACK_STEP(ATTACK_STEP), .RELEASE_STEP(RELEASE_STEP)
  ) u_fsm (
    .CLOCK_50(CLOCK_50), .reset(reset), .gate(gate), .tick(w_tick),
    .env_level(w_level), .active(active), .state(w_state)
  );

  assign w_issue   = r_out_vld & audio_out_allowed;
  assign w_tick    = w_issue && (r_tick_cnt == CNT_LAST);
  assign w_capture = !r_s0_vld && !r_out_vld;

  // Level is non-negative and below 2^ENV_W, so the signed product fits in
  // P_W bits; the mod-2^P_W multiply is exact and bits [P_W-1:ENV_W] are the
  // floor of product >>> ENV_W.
  assign w_a    = {{ENV_W{r_s0_wave[SAMPLE_W-1]}}, r_s0_wave};
  assign w_b    = {{SAMPLE_W{1'b0}}, r_s0_lvl};
  assign w_prod = w_a * w_b;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_s0_vld   <= 1'b0;
      r_s0_wave  <= '0;
      r_s0_lvl   <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_write    <= 1'b0;
    end else begin
      r_write <= w_issue;
      if (w_issue)
        r_tick_cnt <= (r_tick_cnt == CNT_LAST) ? '0 : r_tick_cnt + 1'b1;
      if (w_capture) begin
        r_s0_vld  <= 1'b1;
        r_s0_wave <= wave;
        r_s0_lvl  <= (w_state == IDLE) ? '0 : w_level;
      end else if (r_s0_vld) begin
        r_s0_vld   <= 1'b0;
        r_out_vld  <= 1'b1;
        r_out_data <= w_prod[P_W-1:ENV_W];
      end else if (w_issue) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign left_channel_audio_out  = r_out_data;
  assign right_channel_audio_out = r_out_data;
  assign write_audio_out         = r_write;
  assign env_level               = w_level;
endmodule

// File: tb/tb_audio_envelope_writer.sv
// Directed bench for audio_envelope_writer with TICK_SAMPLES=4, ATTACK_STEP=64.
module tb_audio_envelope_writer;
  logic        clk = 1'b0;
  logic        rst, gate, allowed;
  logic [31:0] wave;
  logic [31:0] left, right;
  logic        wr;
  logic [7:0]  lvl;
  logic        act;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  audio_envelope_writer #(
    .ENV_W(8), .ATTACK_STEP(64), .RELEASE_STEP(1), .TICK_SAMPLES(4)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .gate(gate), .wave(wave),
    .audio_out_allowed(allowed),
    .left_channel_audio_out(left), .right_channel_audio_out(right),
    .write_audio_out(wr), .env_level(lvl), .active(act)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input string tag, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!wr && cyc < budget);
    chk(tag, {31'b0, wr}, 32'd1);
  endtask

  task automatic release_to(input logic [7:0] tgt, input int budget);
    logic [7:0] prev;
    int n;
    prev = lvl;
    n = 0;
    while (lvl != tgt && n < budget) begin
      @(negedge clk);
      n++;
      if (lvl != prev) begin
        chk("rel_step", lvl, prev - 8'd1);
        prev = lvl;
      end
    end
    chk("rel_reach", lvl, tgt);
  endtask

  task automatic wait_change(input int budget);
    logic [7:0] start;
    int n;
    start = lvl;
    n = 0;
    while (lvl == start && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Level visible during the strobe of attack write k (tick on every 4th write).
  function automatic logic [31:0] atk_lvl(input int k);
    if (k >= 16) return 32'd255;
    if (k >= 12) return 32'd192;
    if (k >= 8)  return 32'd128;
    if (k >= 4)  return 32'd64;
    return 32'd0;
  endfunction

  function automatic logic [31:0] atk_data(input int k);
    case (k)
      1, 2, 3, 4:      return 32'h0000_0000;
      5, 6, 7, 8:      return 32'h0040_0000;
      9:               return 32'hFFFF_FF80;
      10:              return 32'hFFFF_FFFF;
      11, 12:          return 32'h0080_0000;
      13, 14, 15, 16:  return 32'h00C0_0000;
      default:         return 32'h00FF_0000;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, last, nwr;

    // Reset state
    rst = 1'b1; gate = 1'b0; allowed = 1'b1; wave = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("rst_left", left, 32'h0);
    chk("rst_right", right, 32'h0);
    chk("rst_wr", {31'b0, wr}, 32'd0);
    chk("rst_lvl", lvl, 32'd0);
    chk("rst_act", {31'b0, act}, 32'd0);
    rst = 1'b0;

    // Idle: zero samples every 3 cycles
    last = 0; nwr = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (wr) begin
        nwr++;
        if (nwr == 1) chk("idle_first", i, 32'd3);
        else          chk("idle_spacing", i - last, 32'd3);
        chk("idle_data", left, 32'h0);
        chk("idle_right", right, 32'h0);
        chk("idle_lvl", lvl, 32'd0);
        chk("idle_act", {31'b0, act}, 32'd0);
        last = i;
      end
    end
    chk("idle_count", nwr, 32'd66);

    // Attack from a clean counter
    @(negedge clk);
    rst = 1'b1; gate = 1'b1; wave = 32'h0100_0000;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      wait_wr("atk_wr", 10, c);
      chk("atk_lvl", lvl, atk_lvl(k));
      chk("atk_data", left, atk_data(k));
      chk("atk_right", right, atk_data(k));
      chk("atk_act", {31'b0, act}, 32'd1);
      wave = (k == 8) ? 32'hFFFF_FF00 : (k == 9) ? 32'hFFFF_FFFF : 32'h0100_0000;
    end

    // Backpressure in SUSTAIN
    wave = 32'h0200_0000; allowed = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      chk("bp_nostrobe", {31'b0, wr}, 32'd0);
      if (i >= 3) begin
        chk("bp_hold_l", left, 32'h01FE_0000);
        chk("bp_hold_r", right, 32'h01FE_0000);
      end
    end
    allowed = 1'b1;
    @(negedge clk);
    chk("bp_strobe", {31'b0, wr}, 32'd1);
    chk("bp_data", left, 32'h01FE_0000);
    @(negedge clk);
    chk("bp_single", {31'b0, wr}, 32'd0);
    wait_wr("bp_resume", 10, c);
    chk("bp_spacing", c, 32'd2);

    // Release, re-attack from the current level
    wave = 32'h0100_0000;
    gate = 1'b0;
    release_to(8'd100, 2500);
    chk("rel_act", {31'b0, act}, 32'd1);
    gate = 1'b1;
    wait_change(20);
    chk("reatk_lvl", lvl, 32'd164);
    chk("reatk_act", {31'b0, act}, 32'd1);
    gate = 1'b0;
    release_to(8'd16, 2500);
    gate = 1'b1;
    wait_change(20);
    chk("reatk80_lvl", lvl, 32'd80);

    // Asynchronous reset with a sample in flight
    wait_wr("pre_rst_wr", 10, c);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_left", left, 32'h0);
    chk("arst_right", right, 32'h0);
    chk("arst_wr", {31'b0, wr}, 32'd0);
    chk("arst_lvl", lvl, 32'd0);
    chk("arst_act", {31'b0, act}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_nostrobe", {31'b0, wr}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_wr("post_rst_wr", 10, c);
      chk("post_rst_data", left, (k == 5) ? 32'h0040_0000 : 32'h0);
      chk("post_rst_lvl", lvl, (k >= 4) ? 32'd64 : 32'd0);
    end

    // Release all the way to IDLE
    gate = 1'b0;
    release_to(8'd0, 1500);
    chk("end_act", {31'b0, act}, 32'd0);
    wait_wr("end_wr1", 10, c);
    chk("end_data1", left, 32'h0);
    wait_wr("end_wr2", 10, c);
    chk("end_data2", left, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/audio_envelope_writer.md
Name: audio_envelope_writer

Overview:
- Downstream of the sine wave generator. Consumes its 32-bit signed `wave` samples and applies a gated attack/sustain/release amplitude envelope.
- Drives the Audio_Controller write port (`left/right_channel_audio_out`, `write_audio_out`), paced by `audio_out_allowed`.
- Replaces the bare `wave*1000` assignment. Keeps the codec FIFO fed with zeros when no note is held.

Parameters:
- ENV_W, 8: envelope level width; ENV_MAX = 2^ENV_W-1.
- ATTACK_STEP, 4: level increment per envelope tick.
- RELEASE_STEP, 1: level decrement per envelope tick.
- TICK_SAMPLES, 48: samples written per envelope tick (1 ms at 48 kHz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- gate  in  1  note held (any key switch active).
- wave  in  32  signed sample from the sine generator; sampled when a new sample is fetched.
- audio_out_allowed  in  1  Audio_Controller output FIFO has space.
- left_channel_audio_out  out  32  signed scaled sample.
- right_channel_audio_out  out  32  identical to left.
- write_audio_out  out  1  one-cycle write strobe.
- env_level  out  ENV_W  current envelope level.
- active  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous) values:
  - all outputs 0
  - state IDLE
  - tick counter 0
  - pipeline empty
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE. Transitions are evaluated on every envelope tick; gate changes are also acted on immediately:
  - IDLE -> ATTACK when gate=1 (next cycle, level starts at 0).
  - ATTACK: level += ATTACK_STEP per tick, saturating at ENV_MAX; on reaching ENV_MAX -> SUSTAIN.
  - SUSTAIN: level holds at ENV_MAX.
  - RELEASE: level -= RELEASE_STEP per tick, clamped at 0; on reaching 0 -> IDLE.
  - gate=0 in ATTACK or SUSTAIN -> RELEASE from the current level.
  - gate=1 in RELEASE -> ATTACK from the current level (no restart from 0).
- Tick counter:
  - Counts completed writes (cycles with `write_audio_out`=1), 0..TICK_SAMPLES-1, then wraps.
  - A tick fires on the write that wraps it.
  - The counter runs in every state. The level does not change in IDLE.
- Sample pipeline, 2 stages:
  - S0: capture `wave` and `env_level`.
  - S1: product = wave * {1'b0, level}, 32x(ENV_W+1) signed, 41 bits. Result = product >>> ENV_W (arithmetic, floor), truncated to 32 bits (it cannot overflow). Result is registered into the output regs; out_valid is set.
  - Latency: capture to out_valid = 2 cycles.
  - A new capture happens only when the pipeline is empty. At most one sample is in flight.
- Write handshake:
  - `write_audio_out` = 1 for exactly one cycle when out_valid=1 and `audio_out_allowed`=1. out_valid clears the same cycle.
  - If `audio_out_allowed`=0, the sample and outputs hold indefinitely with no strobe.
  - The next capture occurs the cycle after the write. Minimum write spacing: 3 cycles.
  - Output data registers hold their last value between writes.
- In IDLE, level=0, so written samples are exactly 0. Writes continue so the codec FIFO never starves.
- Simultaneous events:
  - gate edge on the same cycle as a tick: the state change takes priority. The tick is applied in the new state.
  - A tick's level update affects the next capture only, never a sample already in flight.
- Reset mid-operation: an in-flight sample is dropped, no write strobe is issued, and the level returns to 0 immediately.

Decomposition:
- Shared package (audio_pkg):
  - env_state_t enum (IDLE/ATTACK/SUSTAIN/RELEASE)
  - ENV_W default
  - ENV_MAX
  - SAMPLE_W = 32
- Sub-module `envelope_fsm`:
  - Inputs: CLOCK_50, reset, gate, tick.
  - Outputs: env_level, active, state.
  - Holds the FSM and saturating level arithmetic.
- The top holds the tick counter, sample pipeline and handshake.

Test Plan:
- Reset, then gate=0 and audio_out_allowed=1 for 200 cycles -> write strobes every 3 cycles; data = 0; active=0; env_level=0.
- gate=1, TICK_SAMPLES=4, ATTACK_STEP=64 -> env_level steps 0,64,128,192,255 at every 4th write, then SUSTAIN. wave=32'h0100_0000 at level 255 -> output 32'h00FF_0000.
- Level 128, wave=32'hFFFF_FF00 (-256) -> output 32'hFFFF_FF80 (-128). wave=32'hFFFF_FFFF (-1) -> output 32'hFFFF_FFFF (floor).
- In SUSTAIN, drop gate -> RELEASE. Level decrements by 1 per tick to 0, then IDLE and active=0. Re-raise gate at level 100 -> ATTACK resumes from 100.
- Hold audio_out_allowed=0 for 50 cycles with out_valid=1 -> no strobe; outputs stable. Raise it -> exactly one strobe the next cycle, then the 3-cycle cadence resumes.
- Assert reset mid-pipeline while ATTACK is at level 80 -> outputs and level are 0 asynchronously; no strobe. After release of reset with gate=1 -> ATTACK restarts from 0.
